// File: rtl/mem_pkg.sv
// Shared types, codes and helpers for the EX/MEM data-memory access stage.
package mem_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned BE_W  = XLEN / 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic [2:0] WSEL_ALU  = 3'd0;
  localparam logic [2:0] WSEL_LOAD = 3'd1;
  localparam logic [2:0] WSEL_PC4  = 3'd2;
  localparam logic [2:0] WSEL_IMM  = 3'd3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Access size is the low two funct3 bits for both loads and stores
  localparam logic [1:0] SZ_B = F3_LB[1:0];
  localparam logic [1:0] SZ_H = F3_LH[1:0];
  localparam logic [1:0] SZ_W = F3_LW[1:0];

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      SZ_H:    return a[0];
      SZ_W:    return a != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [BE_W-1:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      SZ_B:    return BE_W'(4'b0001 << a);
      SZ_H:    return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] lane_data(input logic [2:0] f3, input logic [XLEN-1:0] d);
    case (f3[1:0])
      SZ_B:    return {4{d[7:0]}};
      SZ_H:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] wb_mux(input logic [2:0] sel, input logic [XLEN-1:0] alu,
                                             input logic [XLEN-1:0] ld, input logic [XLEN-1:0] pc4,
                                             input logic [XLEN-1:0] imm);
    case (sel)
      WSEL_ALU:  return alu;
      WSEL_LOAD: return ld;
      WSEL_PC4:  return pc4;
      WSEL_IMM:  return imm;
      default:   return '0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-RAM request/response bus between the access stage (master) and the RAM (slave).
interface mem_access_if;
  import mem_pkg::*;

  logic             dm_req;
  logic             dm_we;
  logic [XLEN-1:0]  dm_addr;
  logic [BE_W-1:0]  dm_be;
  logic [XLEN-1:0]  dm_wdata;
  logic             dm_ack;
  logic [XLEN-1:0]  dm_rdata;

  modport master (output dm_req, dm_we, dm_addr, dm_be, dm_wdata, input dm_ack, dm_rdata);
  modport slave  (input dm_req, dm_we, dm_addr, dm_be, dm_wdata, output dm_ack, dm_rdata);

endinterface

// File: rtl/load_align.sv
// Combinational load lane extract and sign/zero extension by address offset and funct3.
module load_align
  import mem_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data_c
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    case (lo)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   data_c = {{24{b[7]}}, b};
      F3_LBU:  data_c = {24'h0, b};
      F3_LH:   data_c = {{16{h[15]}}, h};
      F3_LHU:  data_c = {16'h0, h};
      F3_LW:   data_c = rdata;
      default: data_c = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// EX/MEM data-memory access stage: issues RAM requests, aligns loads, registers writeback.
// Optional MEM_TIMEOUT_EN aborts an access after TIMEOUT_CYC cycles without dm_ack.
module mem_access
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [XLEN-1:0]  alu_c_i,
  input  logic [XLEN-1:0]  rD2_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic [XLEN-1:0]  pc4_i,
  input  logic             ram_we_i,
  input  logic             ram_re_i,
  input  logic [2:0]       funct3_i,
  input  logic             rf_we_i,
  input  logic [2:0]       rf_wsel_i,
  input  logic [REG_W-1:0] wR_i,
  mem_access_if.master     dm,
  output logic             stall_o,
  output logic             wb_valid_o,
  output logic             wb_we_o,
  output logic [REG_W-1:0] wb_wR_o,
  output logic [XLEN-1:0]  wb_wD_o,
  output logic             err_o
);

  state_t state, state_n;

  logic [XLEN-1:0]  c_alu, c_alu_n, c_imm, c_imm_n, c_pc4, c_pc4_n;
  logic [2:0]       c_f3, c_f3_n, c_wsel, c_wsel_n;
  logic             c_st, c_st_n, c_rf_we, c_rf_we_n;
  logic [REG_W-1:0] c_wr, c_wr_n;

  logic             req_q, req_n, we_q, we_n;
  logic [XLEN-1:0]  addr_q, addr_n, wdata_q, wdata_n;
  logic [BE_W-1:0]  be_q, be_n;

  logic             wb_valid_n, wb_we_n, err_n;
  logic [REG_W-1:0] wb_wr_n;
  logic [XLEN-1:0]  wb_wd_n;

  logic             is_mem, mis, tmo_hit;
  logic [XLEN-1:0]  ld_data_c;

  assign is_mem = ram_we_i | ram_re_i;
  assign mis    = misaligned(funct3_i, alu_c_i[1:0]);

  load_align u_load_align (
    .rdata  (dm.dm_rdata),
    .lo     (c_alu[1:0]),
    .funct3 (c_f3),
    .data_c (ld_data_c)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt, cnt_n;
  assign tmo_hit = (state == ACCESS) && !dm.dm_ack && (cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign tmo_hit = 1'b0 && (TIMEOUT_CYC == 0);
`endif

  // The aborting cycle releases the stall so upstream retires the failed entry
  assign stall_o = rst_n & (((state == IDLE) & in_valid & is_mem & ~mis) |
                            ((state == ACCESS) & ~dm.dm_ack & ~tmo_hit));

  assign dm.dm_req   = req_q;
  assign dm.dm_we    = we_q;
  assign dm.dm_addr  = addr_q;
  assign dm.dm_be    = be_q;
  assign dm.dm_wdata = wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next state, captured entry, RAM bus and writeback
  always_comb begin
    state_n    = state;
    c_alu_n    = c_alu;
    c_imm_n    = c_imm;
    c_pc4_n    = c_pc4;
    c_f3_n     = c_f3;
    c_wsel_n   = c_wsel;
    c_st_n     = c_st;
    c_rf_we_n  = c_rf_we;
    c_wr_n     = c_wr;
    req_n      = req_q;
    we_n       = we_q;
    addr_n     = addr_q;
    be_n       = be_q;
    wdata_n    = wdata_q;
    wb_valid_n = 1'b0;
    wb_we_n    = 1'b0;
    wb_wr_n    = wb_wR_o;
    wb_wd_n    = wb_wD_o;
    err_n      = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_n      = cnt;
`endif
    case (state)
      IDLE: begin
        if (in_valid && is_mem && !mis) begin
          state_n   = ACCESS;
          c_alu_n   = alu_c_i;
          c_imm_n   = imm_i;
          c_pc4_n   = pc4_i;
          c_f3_n    = funct3_i;
          c_wsel_n  = rf_wsel_i;
          c_st_n    = ram_we_i;
          c_rf_we_n = rf_we_i;
          c_wr_n    = wR_i;
          req_n     = 1'b1;
          we_n      = ram_we_i;
          addr_n    = {alu_c_i[XLEN-1:2], 2'b00};
          be_n      = byte_en(funct3_i, alu_c_i[1:0]);
          wdata_n   = lane_data(funct3_i, rD2_i);
`ifdef MEM_TIMEOUT_EN
          cnt_n     = '0;
`endif
        end else if (in_valid && is_mem) begin
          wb_valid_n = 1'b1;
          wb_wr_n    = wR_i;
          wb_wd_n    = '0;
          err_n      = 1'b1;
        end else if (in_valid) begin
          wb_valid_n = 1'b1;
          wb_we_n    = rf_we_i && (wR_i != '0);
          wb_wr_n    = wR_i;
          wb_wd_n    = wb_mux(rf_wsel_i, alu_c_i, '0, pc4_i, imm_i);
        end
      end
      ACCESS: begin
        if (dm.dm_ack) begin
          state_n    = IDLE;
          req_n      = 1'b0;
          we_n       = 1'b0;
          wb_valid_n = 1'b1;
          wb_we_n    = c_rf_we && !c_st && (c_wr != '0);
          wb_wr_n    = c_wr;
          wb_wd_n    = wb_mux(c_wsel, c_alu, ld_data_c, c_pc4, c_imm);
        end else if (tmo_hit) begin
          state_n    = IDLE;
          req_n      = 1'b0;
          we_n       = 1'b0;
          wb_valid_n = 1'b1;
          wb_wr_n    = c_wr;
          wb_wd_n    = '0;
          err_n      = 1'b1;
        end else begin
`ifdef MEM_TIMEOUT_EN
          cnt_n = cnt + CNT_W'(1);
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_alu      <= '0;
      c_imm      <= '0;
      c_pc4      <= '0;
      c_f3       <= '0;
      c_wsel     <= '0;
      c_st       <= 1'b0;
      c_rf_we    <= 1'b0;
      c_wr       <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      wb_valid_o <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_wR_o    <= '0;
      wb_wD_o    <= '0;
      err_o      <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt        <= '0;
`endif
    end else begin
      c_alu      <= c_alu_n;
      c_imm      <= c_imm_n;
      c_pc4      <= c_pc4_n;
      c_f3       <= c_f3_n;
      c_wsel     <= c_wsel_n;
      c_st       <= c_st_n;
      c_rf_we    <= c_rf_we_n;
      c_wr       <= c_wr_n;
      req_q      <= req_n;
      we_q       <= we_n;
      addr_q     <= addr_n;
      be_q       <= be_n;
      wdata_q    <= wdata_n;
      wb_valid_o <= wb_valid_n;
      wb_we_o    <= wb_we_n;
      wb_wR_o    <= wb_wr_n;
      wb_wD_o    <= wb_wd_n;
      err_o      <= err_n;
`ifdef MEM_TIMEOUT_EN
      cnt        <= cnt_n;
`endif
    end
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYC, 16, data-RAM wait cycles tolerated before abort (used only with MEM_TIMEOUT_EN).
REQ-002 SHALL have ports (name direction width meaning), in order:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset; one clock; asynchronous, active-low.
- in_valid  in  1  EX/MEM entry present.
- alu_c_i  in  32  ALU result / memory address.
- rD2_i  in  32  store data.
- imm_i, pc4_i  in  32  writeback candidates.
- ram_we_i, ram_re_i  in  1  store / load request.
- funct3_i  in  3  size/sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
- rf_we_i  in  1  regfile write enable.
- rf_wsel_i  in  3  writeback select.
- wR_i  in  5  destination register.
- dm_req, dm_we  out  1  RAM request / write.
- dm_addr  out  32  word-aligned address ({alu_c[31:2],2'b00}).
- dm_be  out  4  byte enables.
- dm_wdata  out  32  lane-replicated store data.
- dm_ack  in  1  RAM completion.
- dm_rdata  in  32  RAM read word, valid with dm_ack.
- stall_o  out  1  upstream hold.
- wb_valid_o, wb_we_o  out  1  writeback entry valid / regfile write.
- wb_wR_o  out  5  writeback register.
- wb_wD_o  out  32  writeback data.
- err_o  out  1  one-cycle pulse: misalign or timeout.

Function
REQ-003 SHALL implement FSM IDLE, ACCESS; reset state IDLE.
REQ-004 Non-memory entry in IDLE SHALL register to wb_* next edge, 1-cycle latency, no stall.
REQ-005 wb_wD_o SHALL select by rf_wsel: 0 alu_c, 1 aligned load data, 2 pc4, 3 imm, others 0.
REQ-006 Aligned memory entry in IDLE SHALL capture all inputs, enter ACCESS, drive dm_req=1 from next cycle.
REQ-007 stall_o SHALL equal (IDLE & in_valid & (ram_we|ram_re) & aligned) | (ACCESS & !dm_ack); upstream holds inputs while high.
REQ-008 In ACCESS dm_req/dm_addr/dm_we/dm_be/dm_wdata SHALL stay stable until dm_ack; on dm_ack edge: wb_* load, state IDLE, dm_req low next cycle.
REQ-009 Minimum memory latency SHALL be 2 cycles (ack in first ACCESS cycle).
REQ-010 Store dm_be: byte 1<<a[1:0]; half 0011/1100 by a[1]; word 1111; wdata replicates byte/half to all lanes.
REQ-011 Load data SHALL extract lane by a[1:0] and sign/zero-extend per funct3.
REQ-012 Misaligned (half with a[0]=1, word with a[1:0]!=0) SHALL issue no request, no stall, pulse err_o, wb_valid_o=1 with wb_we_o=0.
REQ-013 wb_we_o SHALL be 0 when wR=0 or rf_we_i=0; stores never write regfile.
REQ-014 Cycles without in_valid SHALL produce wb_valid_o=0, wb_we_o=0.
REQ-015 dm_ack in IDLE SHALL be ignored.

Reset
REQ-016 rst_n low SHALL immediately force IDLE, dm_req=0, all outputs 0, including mid-ACCESS; no completion after release.

Configuration
REQ-017 MEM_TIMEOUT_EN defined: counter in ACCESS; after TIMEOUT_CYC cycles without dm_ack, drop dm_req, pulse err_o, emit wb_valid_o=1/wb_we_o=0, return IDLE. Undefined: no counter, ACCESS waits indefinitely.

Structure
REQ-018 Package mem_pkg SHALL hold FSM state type, rf_wsel codes, funct3 size codes.
REQ-019 Combinational sub-module load_align SHALL perform lane extract and extension.

Verification
REQ-020 add (alu_c=0x1234, rf_wsel=0, wR=5) -> next cycle wb_wD=0x1234, wb_we=1, stall_o never high.
REQ-021 lb addr 0x103, dm_rdata=0x80FFFFFF, ack after 3 cycles -> dm_be=1000, stall 4 cycles, wb_wD=0xFFFFFF80.
REQ-022 sh addr 0x102, rD2=0xABCD1234 -> dm_be=1100, dm_wdata=0x12341234, dm_we=1, wb_we=0.
REQ-023 lw addr 0x101 -> dm_req stays 0, err_o one pulse, wb_we=0, no stall.
REQ-024 MEM_TIMEOUT_EN, TIMEOUT_CYC=16, no ack -> abort after 16 ACCESS cycles, err_o pulse, IDLE; without macro stall persists.
REQ-025 rst_n low during ACCESS -> dm_req and stall_o 0 immediately; late dm_ack after release produces no wb_valid_o.
